seq_detect_scheduler: RTL
=========================

// Module: seq_detect_scheduler
// PURPOSE
//  Time-shares one Mealy "101" overlapping-sequence engine across N_CH serial bit channels.
//  Holds a 1-bit input buffer and a saved FSM state (context) per channel.
//  Round-robin picks one buffered channel per cycle, steps its context, emits a tagged detect pulse.
//  Sits between N serial bit sources and downstream event logic; replaces N private detectors.
// PARAMETERS
//  N_CH   4  number of input channels (>=2)
//  CNT_W  8  width of per-channel saturating hit counter
//  CH_W   localparam = $clog2(N_CH); channel-index width
// PORTS
//  clk        in   1           system clock; all logic on rising edge
//  reset      in   1           synchronous, active-high reset
//  enable     in   1           1 = arbiter may grant; 0 = freeze stepping
//  in_valid   in   N_CH        per-channel bit offered
//  in_bit     in   N_CH        per-channel serial data bit
//  in_ready   out  N_CH        per-channel buffer empty; bit accepted when in_valid&in_ready
//  ch_clear   in   N_CH        per-channel clear of context + buffer
//  det_valid  out  1           one-cycle pulse: "101" completed on det_ch
//  det_ch     out  CH_W        channel of current detect
//  rd_ch      in   CH_W        counter read select
//  rd_count   out  CNT_W       hit count of channel rd_ch (combinational read)
// BEHAVIOUR
//  Reset: all contexts S_IDLE, buffers empty (in_ready = all 1s), RR pointer = 0,
//   det_valid=0, det_ch=0, all counters 0. Reset mid-stream discards buffered bits.
//  in_ready[i] = ~buf_full[i], driven from a register. A channel takes at most one bit
//   every 2 cycles; no combinational path from in_valid.
//  Arbiter: request[i] = buf_full[i]. Search starts at ptr, wraps modulo N_CH.
//   On grant to channel g: ptr <= g+1 (wraps).
//   No requests, or enable=0: no grant; ptr, contexts and buffers hold.
//  Engine FSM, evaluated on granted channel (ctx, bit):
//   S_IDLE: 1->S_1,  0->S_IDLE
//   S_1:    1->S_1,  0->S_10
//   S_10:   1->S_1 + DETECT (overlap kept), 0->S_IDLE
//  Grant cycle effects, all at one clock edge:
//   ctx[g] <= next, buf_full[g] <= 0.
//   On DETECT: det_valid<=1, det_ch<=g, count[g] += 1, saturating at 2^CNT_W-1.
//   det_valid is otherwise 0. det_ch holds its last value while det_valid=0.
//  Latency: bit accepted at edge k -> earliest grant in cycle k+1 -> det_valid high in cycle k+2.
//   Worst case with all channels busy: N_CH+1 cycles.
//  ch_clear[i] (priority over everything for channel i):
//   ctx[i]<=S_IDLE, buf_full[i]<=0. A bit accepted the same cycle is dropped.
//   A same-cycle grant to i produces no detect and no count change.
//   The grant slot is still consumed: ptr advances.
//   Counter is NOT cleared by ch_clear; only reset clears it.
//  A channel with its bit still buffered keeps in_ready low; the source must hold in_valid.
// STRUCTURE
//  Package seq_detect_pkg: typedef enum logic[1:0] {S_IDLE=0,S_1=1,S_10=2} det_state_t;
//   function step_101(state,bit) returning {next_state, detect}.
//  Sub-module rr_arbiter #(N) (req, ptr -> grant onehot, grant_idx, any); combinational.
//  Top: buffers, context array, ptr, counters, output registers.
// TESTING
//  1 ch0 bits 1,0,1,1,0,1 (others idle) -> det_valid x2, det_ch=0, rd_count(0)=2;
//    1st pulse 2 cycles after 3rd bit accepted.
//  2 ch0/ch1 interleaved, ch0=1,0,1 and ch1=0,0,1 -> one detect on ch0 only;
//    ch1 context unaffected by ch0 bits.
//  3 all 4 buffers filled the same edge, ptr=0 -> grants 0,1,2,3 on consecutive cycles.
//    Refill ch0 and ch3 after ptr=0 -> grant 0 then 3.
//  4 ch2 driven to S_10, then ch_clear[2] with bit 1 pending -> no detect, ctx S_IDLE;
//    next 1,0,1 -> detect.
//  5 CNT_W=2, ch1 fed 1,0,1,0,1,0,1,0,1,0,1 (5 detects) -> rd_count(1)=3, saturated.
//  6 reset asserted between the 0 and the final 1 of a ch3 sequence -> no detect;
//    in_ready=all 1s next cycle; counters 0.
//  7 enable=0 with buffers full -> no grants, in_ready stays 0;
//    enable=1 -> stepping resumes from ptr.

Source files
------------

// File: rtl/seq_detect_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_pkg
//  Brief    : Shared types and the "101" Mealy step function used by the
//             time-shared sequence-detect scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package seq_detect_pkg;

   // Saved per-channel engine context. Encoding 2'd3 is unreachable and is
   // treated like S_IDLE so a corrupted context self-recovers.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_1    = 2'd1,
      S_10   = 2'd2
   } det_state_t;

   typedef struct packed {
      det_state_t next_state;
      logic       detect;
   } step_t;

   // One Mealy step. The detect on S_10 + 1 lands in S_1 so overlapping
   // patterns ("10101" -> two hits) are kept.
   function automatic step_t step_101(input det_state_t state, input logic bit_v);
      step_t r;
      r.next_state = S_IDLE;
      r.detect     = 1'b0;
      case (state)
         S_IDLE:  r.next_state = bit_v ? S_1 : S_IDLE;
         S_1:     r.next_state = bit_v ? S_1 : S_10;
         S_10: begin
            r.next_state = bit_v ? S_1 : S_IDLE;
            r.detect     = bit_v;
         end
         default: r.next_state = bit_v ? S_1 : S_IDLE;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin arbiter. Searches the request vector
//             starting at ptr and wrapping modulo N; first requester wins.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int N = 4,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx,
   output logic         any
);

   logic [W:0]   sum_w;
   logic [W-1:0] idx_w;

   // Rotating priority search; the sum is one bit wider so the wrap can be
   // done with a single compare-and-subtract for any N, not just powers of 2.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      sum_w     = '0;
      idx_w     = '0;
      for (int k = 0; k < N; k++) begin
         sum_w = {1'b0, ptr} + (W+1)'(k);
         if (sum_w >= (W+1)'(N)) begin
            sum_w = sum_w - (W+1)'(N);
         end
         idx_w = sum_w[W-1:0];
         if (!any && req[idx_w]) begin
            any          = 1'b1;
            grant[idx_w] = 1'b1;
            grant_idx    = idx_w;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_detect_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_scheduler
//  Brief    : One "101" overlapping Mealy engine time-shared across N_CH
//             serial bit channels. Each channel owns a 1-bit input buffer, a
//             saved engine context and a saturating hit counter; a round-robin
//             arbiter steps one buffered channel per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_scheduler
   import seq_detect_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH-1:0]   in_bit,
   output logic [N_CH-1:0]   in_ready,
   input  logic [N_CH-1:0]   ch_clear,
   output logic              det_valid,
   output logic [CH_W-1:0]   det_ch,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [CNT_W-1:0]  rd_count
);

   // Per-channel state
   logic [N_CH-1:0]  buf_full_q, buf_full_d;
   logic [N_CH-1:0]  buf_bit_q,  buf_bit_d;
   det_state_t       ctx_q [N_CH];
   det_state_t       ctx_d [N_CH];
   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] cnt_d [N_CH];

   // Shared scheduler state
   logic [CH_W-1:0]  ptr_q, ptr_d;
   logic             det_valid_q, det_valid_d;
   logic [CH_W-1:0]  det_ch_q, det_ch_d;

   // Arbiter results
   logic [N_CH-1:0]  w_grant;
   logic [CH_W-1:0]  w_grant_idx;
   logic             w_any;
   logic             w_fire;
   logic             w_detect;
   step_t            w_step;

   rr_arbiter #(
      .N (N_CH)
   ) u_arb (
      .req       (buf_full_q),
      .ptr       (ptr_q),
      .grant     (w_grant),
      .grant_idx (w_grant_idx),
      .any       (w_any)
   );

   // Ready comes straight from the buffer flag register, so a channel whose
   // bit is being stepped this cycle cannot accept until the next one.
   assign in_ready  = ~buf_full_q;
   assign det_valid = det_valid_q;
   assign det_ch    = det_ch_q;
   assign rd_count  = cnt_q[rd_ch];

   // Next-state: engine step on the granted channel, buffer fill, clear, counters
   always_comb begin
      w_fire   = enable & w_any;
      w_step   = step_101(ctx_q[w_grant_idx], buf_bit_q[w_grant_idx]);
      // A clear on the granted channel kills the detect but still uses the slot.
      w_detect = w_fire & w_step.detect & ~ch_clear[w_grant_idx];

      buf_full_d = buf_full_q;
      buf_bit_d  = buf_bit_q;
      for (int i = 0; i < N_CH; i++) begin
         ctx_d[i] = ctx_q[i];
         cnt_d[i] = cnt_q[i];
         if (ch_clear[i]) begin
            ctx_d[i]      = S_IDLE;
            buf_full_d[i] = 1'b0;
         end else if (w_fire && w_grant[i]) begin
            ctx_d[i]      = w_step.next_state;
            buf_full_d[i] = 1'b0;
            if (w_detect && (cnt_q[i] != {CNT_W{1'b1}})) begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end else if (in_valid[i] && !buf_full_q[i]) begin
            buf_full_d[i] = 1'b1;
            buf_bit_d[i]  = in_bit[i];
         end
      end

      ptr_d = ptr_q;
      if (w_fire) begin
         ptr_d = (w_grant_idx == CH_W'(N_CH - 1)) ? '0 : (w_grant_idx + CH_W'(1));
      end

      det_valid_d = w_detect;
      det_ch_d    = w_detect ? w_grant_idx : det_ch_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_full_q  <= '0;
         buf_bit_q   <= '0;
         ptr_q       <= '0;
         det_valid_q <= 1'b0;
         det_ch_q    <= '0;
         for (int i = 0; i < N_CH; i++) begin
            ctx_q[i] <= S_IDLE;
            cnt_q[i] <= '0;
         end
      end else begin
         buf_full_q  <= buf_full_d;
         buf_bit_q   <= buf_bit_d;
         ptr_q       <= ptr_d;
         det_valid_q <= det_valid_d;
         det_ch_q    <= det_ch_d;
         for (int i = 0; i < N_CH; i++) begin
            ctx_q[i] <= ctx_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule
`default_nettype wire
